// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/squash controller for the RISCII core.
// Drives the S (recirculate) selects of the enable-DFF pipeline registers
// and the NOP-insert selects of IF/ID and ID/EX. Arbitrates fixed-latency
// memory wait-states, load-use hazards and branch flushes.
// Optional feature: define PIPE_STALL_CNT_EN to add the 16-bit saturating
// stallCnt output that counts cycles with holdIF asserted.
module pipe_hold_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReq,
    input  logic        luHazard,
    input  logic        brFlush,
    output logic        holdIF,
    output logic        holdID,
    output logic        holdEX,
    output logic        holdMEM,
    output logic        nopIF,
    output logic        nopID,
    output logic        memBusy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0] stallCnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam bit MEM_EN = (MEM_WAIT != 0);
    // The first stall cycle is spent in IDLE, so WAIT only covers MEM_WAIT-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = MEM_EN ? CNT_W'(MEM_WAIT - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;

    // Next-state and wait-state counter; mem_stall marks a held cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        if (MEM_EN) begin
            case (state_q)
                S_IDLE: begin
                    if (memReq) begin
                        mem_stall = 1'b1;
                        state_d   = S_WAIT;
                        cnt_d     = CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        mem_stall = 1'b1;
                        cnt_d     = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Mealy hold/nop outputs; reset forces every select low immediately.
    always_comb begin
        holdIF  = 1'b0;
        holdID  = 1'b0;
        holdEX  = 1'b0;
        holdMEM = 1'b0;
        nopIF   = 1'b0;
        nopID   = 1'b0;
        memBusy = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                holdIF  = 1'b1;
                holdID  = 1'b1;
                holdEX  = 1'b1;
                holdMEM = 1'b1;
                memBusy = 1'b1;
            end else if (brFlush) begin
                nopIF = 1'b1;
                nopID = 1'b1;
            end else if (luHazard) begin
                holdIF = 1'b1;
                holdID = 1'b1;
                nopID  = 1'b1;
            end
        end
    end

    // FSM state and wait-state counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles with the fetch side held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (holdIF && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed testbench for pipe_hold_ctrl. Three instances share stimulus:
// MEM_WAIT=2 (main), MEM_WAIT=3 (flush during stall), MEM_WAIT=0 (disabled).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Output vectors are {holdIF,holdID,holdEX,holdMEM,nopIF,nopID,memBusy}.
module tb_pipe_hold_ctrl;

    localparam logic [6:0] V_ZERO = 7'b0000000;
    localparam logic [6:0] V_HOLD = 7'b1111001;
    localparam logic [6:0] V_LU   = 7'b1100010;
    localparam logic [6:0] V_FL   = 7'b0000110;

    logic clk, rst, memReq, luHazard, brFlush;
    logic h_if2, h_id2, h_ex2, h_mem2, n_if2, n_id2, busy2;
    logic h_if3, h_id3, h_ex3, h_mem3, n_if3, n_id3, busy3;
    logic h_if0, h_id0, h_ex0, h_mem0, n_if0, n_id0, busy0;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] scnt2, scnt3, scnt0;
`endif
    logic [6:0] o2, o3, o0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    assign o2 = {h_if2, h_id2, h_ex2, h_mem2, n_if2, n_id2, busy2};
    assign o3 = {h_if3, h_id3, h_ex3, h_mem3, n_if3, n_id3, busy3};
    assign o0 = {h_if0, h_id0, h_ex0, h_mem0, n_if0, n_id0, busy0};

    pipe_hold_ctrl #(.MEM_WAIT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .memReq(memReq), .luHazard(luHazard), .brFlush(brFlush),
        .holdIF(h_if2), .holdID(h_id2), .holdEX(h_ex2), .holdMEM(h_mem2),
        .nopIF(n_if2), .nopID(n_id2), .memBusy(busy2)
`ifdef PIPE_STALL_CNT_EN
        , .stallCnt(scnt2)
`endif
    );

    pipe_hold_ctrl #(.MEM_WAIT(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .memReq(memReq), .luHazard(luHazard), .brFlush(brFlush),
        .holdIF(h_if3), .holdID(h_id3), .holdEX(h_ex3), .holdMEM(h_mem3),
        .nopIF(n_if3), .nopID(n_id3), .memBusy(busy3)
`ifdef PIPE_STALL_CNT_EN
        , .stallCnt(scnt3)
`endif
    );

    pipe_hold_ctrl #(.MEM_WAIT(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .memReq(memReq), .luHazard(luHazard), .brFlush(brFlush),
        .holdIF(h_if0), .holdID(h_id0), .holdEX(h_ex0), .holdMEM(h_mem0),
        .nopIF(n_if0), .nopID(n_id0), .memBusy(busy0)
`ifdef PIPE_STALL_CNT_EN
        , .stallCnt(scnt0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] pat [6];
        pat = '{V_HOLD, V_HOLD, V_ZERO, V_HOLD, V_HOLD, V_ZERO};

        // Reset held with memReq high: everything low.
        rst = 1'b1; memReq = 1'b1; luHazard = 1'b0; brFlush = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        check_eq("rst_w2", 32'(o2), 32'(V_ZERO));
        check_eq("rst_w3", 32'(o3), 32'(V_ZERO));
        check_eq("rst_w0", 32'(o0), 32'(V_ZERO));
`ifdef PIPE_STALL_CNT_EN
        check_eq("rst_scnt", 32'(scnt2), 32'd0);
`endif

        // Release reset with memReq high: 1,1,0,1,1,0 holds; MEM_WAIT=0 stays idle.
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            check_eq($sformatf("mem_pat%0d", i), 32'(o2), 32'(pat[i]));
            check_eq($sformatf("w0_idle%0d", i), 32'(o0), 32'(V_ZERO));
        end
`ifdef PIPE_STALL_CNT_EN
        check_eq("scnt_2acc", 32'(scnt2), 32'd4);
`endif

        cyc();
        memReq = 1'b0;
        @(negedge clk);
        check_eq("idle", 32'(o2), 32'(V_ZERO));

        // Load-use bubble for one cycle.
        cyc();
        luHazard = 1'b1;
        @(negedge clk);
        check_eq("lu_hazard", 32'(o2), 32'(V_LU));
        cyc();
        luHazard = 1'b0;
        @(negedge clk);
        check_eq("lu_clear", 32'(o2), 32'(V_ZERO));
`ifdef PIPE_STALL_CNT_EN
        check_eq("scnt_lu", 32'(scnt2), 32'd5);
`endif

        // Flush beats hazard.
        cyc();
        brFlush = 1'b1; luHazard = 1'b1;
        @(negedge clk);
        check_eq("flush_vs_lu", 32'(o2), 32'(V_FL));
        cyc();
        luHazard = 1'b0;
        @(negedge clk);
        check_eq("flush_only", 32'(o2), 32'(V_FL));
        cyc();
        brFlush = 1'b0;
        @(negedge clk);
        check_eq("flush_clear", 32'(o2), 32'(V_ZERO));

        // Reset mid-WAIT (cnt=1) drops outputs at once; restart pays full stall.
        cyc();
        memReq = 1'b1;
        @(negedge clk);
        check_eq("mw_stall1", 32'(o2), 32'(V_HOLD));
        cyc();
        @(negedge clk);
        check_eq("mw_stall2", 32'(o2), 32'(V_HOLD));
        #1 rst = 1'b1;
        #1;
        check_eq("rst_midwait", 32'(o2), 32'(V_ZERO));
`ifdef PIPE_STALL_CNT_EN
        check_eq("rst_midwait_scnt", 32'(scnt2), 32'd0);
`endif
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_eq("restart1", 32'(o2), 32'(V_HOLD));
        cyc();
        @(negedge clk);
        check_eq("restart2", 32'(o2), 32'(V_HOLD));
        cyc();
        @(negedge clk);
        check_eq("restart_rel", 32'(o2), 32'(V_ZERO));
`ifdef PIPE_STALL_CNT_EN
        check_eq("scnt_restart", 32'(scnt2), 32'd2);
`endif

        // MEM_WAIT=3: flush raised on 2nd stall cycle is deferred to release.
        cyc();
        rst = 1'b1; memReq = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_eq("w3_idle", 32'(o3), 32'(V_ZERO));
        cyc();
        memReq = 1'b1;
        @(negedge clk);
        check_eq("w3_stall1", 32'(o3), 32'(V_HOLD));
        cyc();
        brFlush = 1'b1;
        @(negedge clk);
        check_eq("w3_stall2_fl", 32'(o3), 32'(V_HOLD));
        cyc();
        @(negedge clk);
        check_eq("w3_stall3_fl", 32'(o3), 32'(V_HOLD));
        cyc();
        @(negedge clk);
        check_eq("w3_release_fl", 32'(o3), 32'(V_FL));
        cyc();
        memReq = 1'b0; brFlush = 1'b0;
        @(negedge clk);
        check_eq("w3_done", 32'(o3), 32'(V_ZERO));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
